// File: rtl/sha_wb_master_if.sv
// Wishbone classic bus bundle between the SHA feeder master and the SHA slave port.
interface sha_wb_master_if #(
   parameter int BITS = 32
);
   logic            cyc;
   logic            stb;
   logic            we;
   logic [3:0]      sel;
   logic [31:0]     adr;
   logic [BITS-1:0] dat_w;
   logic [BITS-1:0] dat_r;
   logic            ack;

   modport master (output cyc, stb, we, sel, adr, dat_w, input dat_r, ack);
   modport slave  (input cyc, stb, we, sel, adr, dat_w, output dat_r, ack);
endinterface

// File: rtl/sha_wb_master.sv
// Wishbone classic master: writes one message block to the SHA slave, then reads the digest back.
// Optional ack watchdog with sticky timeout_err is built when SHA_WB_MASTER_TIMEOUT_EN is defined.
//
// state  | meaning
// IDLE   | waiting for start
// WR_REQ | write strobe for block word idx, held until ack
// WR_GAP | one stb-low cycle after a write ack
// RD_REQ | read strobe for digest word idx, held until ack
// RD_GAP | one stb-low cycle after a read ack
// FIN    | bus released, done pulse
module sha_wb_master #(
   parameter int          BITS           = 32,
   parameter int          BLOCK_WORDS    = 16,
   parameter int          DIGEST_WORDS   = 5,
   parameter logic [31:0] BASE_ADR       = 32'h3000_0000,
   parameter logic [31:0] RD_OFFSET      = 32'h0000_0040,
   parameter int          TIMEOUT_CYCLES = 1023
) (
   input  logic                         clk,
   input  logic                         rst,
   input  logic                         start,
   input  logic [BLOCK_WORDS*BITS-1:0]  block_i,
   output logic                         busy,
   output logic                         done,
   output logic                         timeout_err,
   output logic [DIGEST_WORDS*BITS-1:0] digest_o,
   sha_wb_master_if.master              wb
);
   localparam logic [2:0] ST_IDLE   = 3'd0;
   localparam logic [2:0] ST_WR_REQ = 3'd1;
   localparam logic [2:0] ST_WR_GAP = 3'd2;
   localparam logic [2:0] ST_RD_REQ = 3'd3;
   localparam logic [2:0] ST_RD_GAP = 3'd4;
   localparam logic [2:0] ST_FIN    = 3'd5;

   localparam int IDX_N = (BLOCK_WORDS > DIGEST_WORDS) ? BLOCK_WORDS : DIGEST_WORDS;
   localparam int IDX_W = (IDX_N > 1) ? $clog2(IDX_N) : 1;
   localparam logic [IDX_W-1:0] WR_LAST = IDX_W'(BLOCK_WORDS - 1);
   localparam logic [IDX_W-1:0] RD_LAST = IDX_W'(DIGEST_WORDS - 1);

   logic [2:0]       state;
   logic [IDX_W-1:0] idx;
   logic [BITS-1:0]  blk_q [BLOCK_WORDS];
   logic [BITS-1:0]  dig_q [DIGEST_WORDS];
   logic [BITS-1:0]  wr_word;
   logic [31:0]      word_off;
   logic             abort;

`ifdef SHA_WB_MASTER_TIMEOUT_EN
   localparam int WAIT_W = ($clog2(TIMEOUT_CYCLES + 1) > 10) ? $clog2(TIMEOUT_CYCLES + 1) : 10;
   logic [WAIT_W-1:0] wait_cnt;
   logic              err_q;

   // Counter is held at zero outside the strobe states, so it restarts on every request.
   always_ff @(posedge clk) begin
      if (rst || !wb.stb || wb.ack) begin
         wait_cnt <= '0;
      end else begin
         wait_cnt <= wait_cnt + 1'b1;
      end
   end

   assign abort = wb.stb && !wb.ack && (wait_cnt == WAIT_W'(TIMEOUT_CYCLES - 1));

   always_ff @(posedge clk) begin
      if (rst) begin
         err_q <= 1'b0;
      end else if (state == ST_IDLE && start) begin
         err_q <= 1'b0;
      end else if (abort) begin
         err_q <= 1'b1;
      end
   end

   assign timeout_err = err_q;
`else
   assign abort       = 1'b0;
   assign timeout_err = 1'b0;
`endif

   always_ff @(posedge clk) begin
      if (rst) begin
         state <= ST_IDLE;
         idx   <= '0;
         for (int j = 0; j < BLOCK_WORDS; j++) blk_q[j] <= '0;
         for (int j = 0; j < DIGEST_WORDS; j++) dig_q[j] <= '0;
      end else begin
         case (state)
            ST_IDLE: begin
               if (start) begin
                  for (int j = 0; j < BLOCK_WORDS; j++)
                     blk_q[j] <= block_i[(BLOCK_WORDS-1-j)*BITS +: BITS];
                  idx   <= '0;
                  state <= ST_WR_REQ;
               end
            end
            ST_WR_REQ: begin
               if (wb.ack)     state <= ST_WR_GAP;
               else if (abort) state <= ST_IDLE;
            end
            ST_WR_GAP: begin
               if (idx == WR_LAST) begin
                  idx   <= '0;
                  state <= ST_RD_REQ;
               end else begin
                  idx   <= idx + 1'b1;
                  state <= ST_WR_REQ;
               end
            end
            ST_RD_REQ: begin
               if (wb.ack) begin
                  for (int j = 0; j < DIGEST_WORDS; j++)
                     if (idx == IDX_W'(j)) dig_q[j] <= wb.dat_r;
                  state <= ST_RD_GAP;
               end else if (abort) begin
                  state <= ST_IDLE;
               end
            end
            ST_RD_GAP: begin
               if (idx == RD_LAST) begin
                  state <= ST_FIN;
               end else begin
                  idx   <= idx + 1'b1;
                  state <= ST_RD_REQ;
               end
            end
            ST_FIN:  state <= ST_IDLE;
            default: state <= ST_IDLE;
         endcase
      end
   end

   always_comb begin
      wr_word = '0;
      for (int j = 0; j < BLOCK_WORDS; j++)
         if (idx == IDX_W'(j)) wr_word = blk_q[j];
   end

   assign word_off = 32'(idx) << 2;

   // Bus outputs decode straight from the registered state, so they are glitch-free per cycle.
   always_comb begin
      wb.cyc   = (state == ST_WR_REQ) || (state == ST_WR_GAP) ||
                 (state == ST_RD_REQ) || (state == ST_RD_GAP);
      wb.stb   = (state == ST_WR_REQ) || (state == ST_RD_REQ);
      wb.we    = (state == ST_WR_REQ);
      wb.sel   = (state == ST_WR_REQ) ? 4'hF : 4'h0;
      wb.adr   = '0;
      wb.dat_w = '0;
      if (state == ST_WR_REQ) begin
         wb.adr   = BASE_ADR + word_off;
         wb.dat_w = wr_word;
      end else if (state == ST_RD_REQ) begin
         wb.adr   = BASE_ADR + RD_OFFSET + word_off;
      end
   end

   always_comb begin
      digest_o = '0;
      for (int j = 0; j < DIGEST_WORDS; j++)
         digest_o[(DIGEST_WORDS-1-j)*BITS +: BITS] = dig_q[j];
   end

   assign busy = (state != ST_IDLE);
   assign done = (state == ST_FIN);
endmodule

// File: tb/tb_sha_wb_master.sv
// Directed/randomized bench for sha_wb_master with a transaction-level slave model.
// Exercises the timeout path when SHA_WB_MASTER_TIMEOUT_EN is defined, the infinite wait otherwise.
module tb_sha_wb_master;
   localparam int          BITS  = 32;
   localparam int          BW    = 16;
   localparam int          DW    = 5;
   localparam int          NTX   = BW + DW;
   localparam logic [31:0] BASE  = 32'h3000_0000;
   localparam logic [31:0] RDOFF = 32'h0000_0040;
   localparam int          TMO   = 16;

   logic                 clk = 1'b0;
   logic                 rst = 1'b1;
   logic                 start = 1'b0;
   logic [BW*BITS-1:0]   block_i = '0;
   logic                 busy, done, timeout_err;
   logic [DW*BITS-1:0]   digest_o;

   sha_wb_master_if #(.BITS(BITS)) wb ();

   sha_wb_master #(
      .BITS(BITS), .BLOCK_WORDS(BW), .DIGEST_WORDS(DW),
      .BASE_ADR(BASE), .RD_OFFSET(RDOFF), .TIMEOUT_CYCLES(TMO)
   ) dut (
      .clk(clk), .rst(rst), .start(start), .block_i(block_i),
      .busy(busy), .done(done), .timeout_err(timeout_err),
      .digest_o(digest_o), .wb(wb)
   );

   always #5 clk = ~clk;

   int nchk = 0;
   int nfail = 0;

   logic [31:0] blk_w [BW];
   logic [31:0] rd_w  [DW];
   int          dly   [NTX];

   int r_done_cnt, r_done_cyc, r_txn, r_stb_run;
   bit r_aborted, r_rst_hit;

   task automatic chk(input string tag, input logic [191:0] obs, input logic [191:0] exp);
      nchk++;
      assert (obs === exp) else begin
         nfail++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   function automatic logic [68:0] exp_bus(input int t);
      if (t < BW) return {1'b1, 4'hF, BASE + 32'(4 * t), blk_w[t]};
      else        return {1'b0, 4'h0, BASE + RDOFF + 32'(4 * (t - BW)), 32'h0};
   endfunction

   function automatic logic [DW*BITS-1:0] exp_digest();
      logic [DW*BITS-1:0] d = '0;
      for (int j = 0; j < DW; j++) d = (d << BITS) | (DW*BITS)'(rd_w[j]);
      return d;
   endfunction

   // start cycle is cycle 0; each transfer takes its wait plus one ack cycle plus one gap cycle
   function automatic int exp_latency();
      int s = 1;
      for (int i = 0; i < NTX; i++) s += dly[i] + 2;
      return s;
   endfunction

   function automatic logic [BW*BITS-1:0] pack_block();
      logic [BW*BITS-1:0] b = '0;
      for (int k = 0; k < BW; k++) b = (b << BITS) | (BW*BITS)'(blk_w[k]);
      return b;
   endfunction

   task automatic set_data(input bit fixed);
      for (int k = 0; k < BW; k++) blk_w[k] = fixed ? 32'(k) : $urandom;
      for (int j = 0; j < DW; j++) rd_w[j] = fixed ? (32'hA000_0000 + 32'(j)) : $urandom;
      for (int i = 0; i < NTX; i++) dly[i] = 0;
   endtask

   task automatic run(input int budget, input bit spur, input int start_at, input int rst_at);
      int t = 0;
      int sc = 0;
      int gap = 0;
      r_done_cnt = 0; r_done_cyc = -1; r_aborted = 0; r_rst_hit = 0;
      block_i = pack_block();
      start = 1'b1;
      for (int n = 1; n <= budget; n++) begin
         @(negedge clk);
         start = 1'b0;
         wb.ack = 1'b0;
         wb.dat_r = $urandom;
         if (done) begin
            r_done_cnt++;
            r_done_cyc = n;
            break;
         end
         if (!wb.cyc) begin
            r_aborted = 1;
            break;
         end
         if (wb.stb) begin
            if (sc == 0 && t > 0) chk("gap_len", 192'(gap), 192'(1));
            gap = 0;
            chk("bus", {123'd0, wb.we, wb.sel, wb.adr, wb.dat_w}, {123'd0, exp_bus(t)});
            if (t == start_at && sc == 0) begin
               start = 1'b1;
               block_i = {16{$urandom}};
            end
            if (t == rst_at) begin
               rst = 1'b1;
               r_rst_hit = 1;
               break;
            end
            if (sc >= dly[t]) begin
               wb.ack = 1'b1;
               if (t >= BW) wb.dat_r = rd_w[t - BW];
               t++;
               sc = 0;
            end else begin
               sc++;
            end
         end else begin
            gap++;
            wb.ack = spur;
         end
      end
      r_txn = t;
      r_stb_run = sc;
      wb.ack = 1'b0;
      start = 1'b0;
   endtask

   task automatic check_complete(input int lat);
      chk("done_count", 192'(r_done_cnt), 192'(1));
      chk("done_cycle", 192'(r_done_cyc), 192'(lat));
      chk("transfers", 192'(r_txn), 192'(NTX));
      chk("digest", 192'(digest_o), 192'(exp_digest()));
      @(negedge clk);
      chk("after_done", {190'd0, busy, done}, 192'd0);
      chk("digest_hold", 192'(digest_o), 192'(exp_digest()));
   endtask

   initial begin
      wb.ack = 1'b0;
      wb.dat_r = '0;
      set_data(1'b1);

      // reset state
      repeat (2) @(negedge clk);
      chk("reset_outs", {181'd0, busy, done, timeout_err, wb.cyc, wb.stb, wb.we, wb.sel}, 192'd0);
      chk("reset_bus", {128'd0, wb.adr, wb.dat_w}, 192'd0);
      chk("reset_digest", 192'(digest_o), 192'd0);
      rst = 1'b0;
      @(negedge clk);

      // 1: fixed pattern, ack in first strobe cycle
      set_data(1'b1);
      run(200, 1'b0, -1, -1);
      chk("lat_min", 192'(exp_latency()), 192'(43));
      check_complete(exp_latency());

      // 2: long waits on write 3 and read 0, same digest
      set_data(1'b1);
      dly[3] = 7;
      dly[BW] = 200;
      run(600, 1'b0, -1, -1);
      check_complete(exp_latency());

      // 3: start pulse during write 5 plus spurious acks in every gap
      set_data(1'b0);
      for (int i = 0; i < NTX; i++) dly[i] = int'($urandom_range(0, 3));
      run(400, 1'b1, 5, -1);
      check_complete(exp_latency());

      // 4: reset during read 2, then a clean run
      set_data(1'b0);
      run(200, 1'b0, -1, BW + 2);
      chk("rst_hit", 192'(r_rst_hit), 192'(1));
      @(negedge clk);
      rst = 1'b0;
      chk("rst_bus", {189'd0, wb.cyc, wb.stb, wb.we}, 192'd0);
      chk("rst_status", {190'd0, busy, done}, 192'd0);
      chk("rst_digest", 192'(digest_o), 192'd0);
      set_data(1'b0);
      for (int i = 0; i < NTX; i++) dly[i] = int'($urandom_range(0, 2));
      run(400, 1'b0, -1, -1);
      check_complete(exp_latency());

`ifdef SHA_WB_MASTER_TIMEOUT_EN
      // 5: read 0 never acked -> abort after TMO strobe cycles
      set_data(1'b0);
      dly[BW] = 1 << 30;
      run(300, 1'b0, -1, -1);
      chk("tmo_aborted", 192'(r_aborted), 192'(1));
      chk("tmo_txn", 192'(r_txn), 192'(BW));
      chk("tmo_stb_cycles", 192'(r_stb_run), 192'(TMO));
      chk("tmo_done", 192'(r_done_cnt), 192'd0);
      chk("tmo_status", {190'd0, busy, timeout_err}, 192'd1);
      for (int i = 0; i < 3; i++) begin
         wb.ack = 1'b1;
         @(negedge clk);
         chk("tmo_sticky", {188'd0, wb.cyc, busy, done, timeout_err}, 192'd1);
      end
      wb.ack = 1'b0;
      set_data(1'b0);
      run(200, 1'b0, -1, -1);
      chk("tmo_cleared", 192'(timeout_err), 192'd0);
      check_complete(exp_latency());
`else
      // 6: read 0 never acked -> master keeps waiting
      set_data(1'b0);
      dly[BW] = 1 << 30;
      run(2 * BW + 1 + 1000, 1'b0, -1, -1);
      chk("wait_txn", 192'(r_txn), 192'(BW));
      chk("wait_long", 192'(r_stb_run >= 1000), 192'd1);
      chk("wait_no_done", 192'(r_done_cnt), 192'd0);
      chk("wait_stb", {189'd0, wb.cyc, wb.stb, timeout_err}, 192'd6);
      rst = 1'b1;
      @(negedge clk);
      rst = 1'b0;
      chk("wait_rst", {189'd0, wb.cyc, wb.stb, busy}, 192'd0);
`endif

      $display("TB_RESULT checks=%0d failures=%0d", nchk, nfail);
      $finish;
   end
endmodule
